fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 4, the instruction-queue entry count (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port icache_addr  output  32  fetch address presented to icache.
REQ-006 SHALL have port icache_data  input  32  instruction for the address presented the previous cycle.
REQ-007 SHALL have port icache_stall  input  1  high means icache_data is invalid this cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/exception redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target, word aligned.
REQ-010 SHALL have port dec_valid  output  1  queue head valid toward decode.
REQ-011 SHALL have port dec_ready  input  1  decode accepts head this cycle.
REQ-012 SHALL have port dec_instr  output  32  instruction at queue head.
REQ-013 SHALL have port dec_pc  output  32  PC of instruction at queue head.

Function
REQ-014 SHALL hold registers pc_f (address issued this cycle), inflight_pc, inflight_v (request issued last cycle) and the queue; icache_addr SHALL equal pc_f.
REQ-015 Icache contract: icache_data in cycle t+1 belongs to icache_addr in cycle t; it is valid only when icache_stall is low in t+1.
REQ-016 Response accept SHALL be inflight_v & ~icache_stall & ~redirect_valid & space, where space = (count < QDEPTH) | (dec_valid & dec_ready).
REQ-017 On accept, SHALL enqueue {inflight_pc, icache_data} at tail.
REQ-018 Priority 1, redirect_valid: pc_f <= redirect_pc, inflight_v <= 0, queue flushed to empty after any same-cycle dequeue; the in-flight response is discarded.
REQ-019 Priority 2, replay (inflight_v & (icache_stall | ~space)): pc_f <= inflight_pc, inflight_v <= 0; the current pc_f issue is dropped.
REQ-020 Priority 3, otherwise: inflight_pc <= pc_f, inflight_v <= 1, pc_f <= pc_f + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 dec_valid SHALL equal (count != 0); dec_instr/dec_pc SHALL be the head entry, stable while dec_valid & ~dec_ready.
REQ-022 Dequeue SHALL occur when dec_valid & dec_ready; simultaneous enqueue and dequeue SHALL keep count unchanged, including at count == QDEPTH.
REQ-023 head/tail pointers SHALL wrap modulo QDEPTH; count SHALL range 0..QDEPTH and never over- or underflow.
REQ-024 In steady state with no stall and dec_ready high, one instruction per cycle SHALL reach decode; first instruction after reset or redirect appears on dec_valid 2 cycles after the address is issued.
REQ-025 Instruction order at dec_* SHALL equal program order of accepted responses; no duplicate or skipped PC except across a redirect.

Reset
REQ-026 On rst high, asynchronously: pc_f = RESET_PC, inflight_pc = 0, inflight_v = 0, queue empty, head = tail = count = 0, so dec_valid = 0 and icache_addr = RESET_PC.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight and queued instructions; fetch restarts at RESET_PC the first edge after rst deasserts.
REQ-028 Queue payload storage need not be reset; dec_instr/dec_pc are don't-care while dec_valid = 0.

Structure
REQ-029 Shared package fetch_pkg SHALL hold FETCH_RESET_PC, the instruction-width constant and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-030 The queue SHALL be a sub-module fetch_queue (parameter QDEPTH; enq, deq, flush, full/empty/count); PC and replay logic stay in fetch_unit.

Verification
REQ-031 Reset, no stall, dec_ready=1 -> icache_addr 0,4,8,...; dec_pc 0,4,8 on consecutive cycles from cycle 2; dec_instr matches model.
REQ-032 icache_stall high 3 cycles while inflight_pc=0x10 -> 0x10 re-presented, no enqueue during stall, dec_pc sequence ...0xC,0x10,0x14 with no gap or duplicate.
REQ-033 dec_ready=0 for 10 cycles -> count saturates at 4, dec_pc holds 0x0, no loss; on release dec_pc 0x0,0x4,0x8,0xC,0x10 in order.
REQ-034 redirect_valid with redirect_pc=0x200 while queue holds 3 entries and dec_ready=1 -> head consumed that cycle, rest flushed, next dec_pc = 0x200.
REQ-035 redirect_valid coincident with icache_stall and full queue -> redirect wins; icache_addr = 0x200 next cycle; queue empty.
REQ-036 redirect_pc=32'hFFFF_FFF8 -> dec_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst pulsed mid-stream -> dec_valid drops immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // One instruction-queue slot: the fetch address and the word returned for it.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between the fetch pipeline and decode.
// Flush empties the queue and takes priority over any same-cycle enqueue/dequeue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enq,
  input  fetch_entry_t       i_enq_entry,
  input  logic               i_deq,
  input  logic               i_flush,
  output fetch_entry_t       o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [CNT_W-1:0]   o_count
);

  fetch_entry_t     r_mem [QDEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_do_enq;
  logic w_do_deq;

  assign o_full  = (r_count == CNT_W'(QDEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // Guard against overflow/underflow; enqueue into a full queue is legal only alongside a dequeue.
  assign w_do_enq = i_enq & (~o_full | i_deq) & ~i_flush;
  assign w_do_deq = i_deq & ~o_empty;

  // Pointer and occupancy state; pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_do_deq) r_head <= r_head + PTR_W'(1);
      unique case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is not reset; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_tail] <= i_enq_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the icache address, tracks the single in-flight request,
// replays it on stall or back-pressure, and feeds accepted words into the decode queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [31:0]         icache_addr,
  input  logic [INSTR_W-1:0]  icache_data,
  input  logic                icache_stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [INSTR_W-1:0]  dec_instr,
  output logic [31:0]         dec_pc
);

  localparam int unsigned CNT_W = ((QDEPTH > 1) ? $clog2(QDEPTH) : 1) + 1;

  logic [31:0] r_pc_f;
  logic [31:0] r_inflight_pc;
  logic        r_inflight_v;

  logic [31:0] w_pc_f_d;
  logic [31:0] w_inflight_pc_d;
  logic        w_inflight_v_d;

  logic             w_deq;
  logic             w_space;
  logic             w_accept;
  logic             w_replay;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_enq_entry;
  fetch_entry_t     w_head;

  assign icache_addr = r_pc_f;
  assign dec_valid   = (w_count != '0);
  assign dec_instr   = w_head.instr;
  assign dec_pc      = w_head.pc;

  assign w_deq       = dec_valid & dec_ready;
  // A slot is free if the queue is not full or the head leaves this cycle.
  assign w_space     = ~w_full | w_deq;
  assign w_accept    = r_inflight_v & ~icache_stall & ~redirect_valid & w_space;
  assign w_replay    = r_inflight_v & (icache_stall | ~w_space);
  assign w_enq_entry = '{pc: r_inflight_pc, instr: icache_data};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_enq       (w_accept),
    .i_enq_entry (w_enq_entry),
    .i_deq       (w_deq),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Next fetch state: redirect beats replay beats sequential issue.
  always_comb begin
    w_pc_f_d        = r_pc_f;
    w_inflight_pc_d = r_inflight_pc;
    w_inflight_v_d  = r_inflight_v;
    if (redirect_valid) begin
      w_pc_f_d       = redirect_pc;
      w_inflight_v_d = 1'b0;
    end else if (w_replay) begin
      // Re-present the unaccepted address; whatever pc_f issued this cycle is dropped.
      w_pc_f_d       = r_inflight_pc;
      w_inflight_v_d = 1'b0;
    end else begin
      w_inflight_pc_d = r_pc_f;
      w_inflight_v_d  = 1'b1;
      w_pc_f_d        = r_pc_f + 32'd4;
    end
  end

  // Fetch PC and in-flight tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_f        <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight_v  <= 1'b0;
    end else begin
      r_pc_f        <= w_pc_f_d;
      r_inflight_pc <= w_inflight_pc_d;
      r_inflight_v  <= w_inflight_v_d;
    end
  end

  // The queue's empty flag and occupancy count must always agree.
  a_empty_count: assert property (@(posedge clk) disable iff (rst) w_empty == (w_count == '0));

endmodule
